// File: rtl/dispatch_nw.sv
// dispatch_nw: N-wide dispatch stage between rename and the ROB / issue queues.
//
// A whole rename bundle is registered in a stage of WIDTH slots and sent out
// strictly in program order, possibly over several cycles, limited by ROB and
// per-queue free space. Lanes that do not go are shifted down to slot 0 and
// retried next cycle.
//
// Handshake: in_valid[0] & in_ready loads the entire bundle at the rising edge.
// in_ready is high only when every valid slot leaves this cycle (or the stage
// is empty) and there is no flush or reset; enqueue strobes are one-cycle
// pulses that the consumers take unconditionally, since the free counts were
// already honoured here.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   in_*                     rename bundle (valids contiguous from lane 0)
//   rob_free/rob_tail_robid  ROB capacity and first ROB id this cycle
//   intisq_free/memisq_free  issue-queue capacities this cycle
//   *_enq_valid, out_*       per-lane dispatch strobes and lane data
//   bt_*                     busy-table read, busy bits and allocation
//   wb_valid/wb_preg         writeback bypass for sleep bits
//   flush_valid              drop everything in the stage and at the input
//   stall_cycles             saturating count of blocked cycles
module dispatch_nw #(
  parameter int WIDTH     = 2,
  parameter int DATA_W    = 248,
  parameter int PREG_W    = 6,
  parameter int ROB_DEPTH = 64,
  parameter int ROBID_W   = 7,
  parameter int NWB       = 2,
  parameter int CNT_W     = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*DATA_W-1:0]   in_payload,
  input  logic [WIDTH*PREG_W-1:0]   in_prd,
  input  logic [WIDTH*PREG_W-1:0]   in_prs1,
  input  logic [WIDTH*PREG_W-1:0]   in_prs2,
  input  logic [WIDTH-1:0]          in_need_wb,
  input  logic [WIDTH-1:0]          in_src1_is_reg,
  input  logic [WIDTH-1:0]          in_src2_is_reg,
  input  logic [WIDTH-1:0]          in_is_mem,
  input  logic [CNT_W-1:0]          rob_free,
  input  logic [ROBID_W-1:0]        rob_tail_robid,
  input  logic [CNT_W-1:0]          intisq_free,
  input  logic [CNT_W-1:0]          memisq_free,
  output logic [WIDTH-1:0]          rob_enq_valid,
  output logic [WIDTH-1:0]          intisq_enq_valid,
  output logic [WIDTH-1:0]          memisq_enq_valid,
  output logic [WIDTH*DATA_W-1:0]   out_payload,
  output logic [WIDTH*ROBID_W-1:0]  out_robid,
  output logic [WIDTH-1:0]          out_sleep1,
  output logic [WIDTH-1:0]          out_sleep2,
  output logic [2*WIDTH*PREG_W-1:0] bt_rdaddr,
  input  logic [2*WIDTH-1:0]        bt_busy,
  output logic [WIDTH-1:0]          bt_alloc_en,
  output logic [WIDTH*PREG_W-1:0]   bt_alloc_addr,
  input  logic [NWB-1:0]            wb_valid,
  input  logic [NWB*PREG_W-1:0]     wb_preg,
  input  logic                      flush_valid,
  output logic [31:0]               stall_cycles
);

  // Stage slots
  logic [WIDTH-1:0]        valid_q, valid_d;
  logic [WIDTH*DATA_W-1:0] payload_q, payload_d;
  logic [WIDTH*PREG_W-1:0] prd_q, prd_d, prs1_q, prs1_d, prs2_q, prs2_d;
  logic [WIDTH-1:0]        need_wb_q, need_wb_d, src1_q, src1_d, src2_q, src2_d;
  logic [WIDTH-1:0]        mem_q, mem_d;
  logic [31:0]             stall_q, stall_d;

  logic [CNT_W-1:0] disp_cnt, valid_cnt, n_int, n_mem;
  logic             blocked, go, fire, hit1, hit2, dep1, dep2;
  logic [PREG_W-1:0] ps1, ps2, pd;

  assign go = ~reset & ~flush_valid;

  // Dispatch count: longest in-order prefix that fits. Comparing running
  // counts (never above WIDTH) against the raw free counts gives the same
  // result as clamping the free counts to WIDTH first.
  always_comb begin
    disp_cnt  = '0;
    valid_cnt = '0;
    n_int     = '0;
    n_mem     = '0;
    blocked   = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (valid_q[k]) begin
        valid_cnt = valid_cnt + CNT_W'(1);
        if (mem_q[k]) n_mem = n_mem + CNT_W'(1);
        else          n_int = n_int + CNT_W'(1);
        if (!blocked && (CNT_W'(k + 1) <= rob_free) &&
            (n_int <= intisq_free) && (n_mem <= memisq_free))
          disp_cnt = CNT_W'(k + 1);
        else
          blocked = 1'b1;
      end
    end
  end

  // Per-lane outputs
  always_comb begin
    in_ready         = go & (disp_cnt == valid_cnt);
    rob_enq_valid    = '0;
    intisq_enq_valid = '0;
    memisq_enq_valid = '0;
    bt_alloc_en      = '0;
    bt_alloc_addr    = prd_q;
    out_payload      = payload_q;
    out_robid        = '0;
    out_sleep1       = '0;
    out_sleep2       = '0;
    bt_rdaddr        = '0;
    fire = 1'b0; hit1 = 1'b0; hit2 = 1'b0; dep1 = 1'b0; dep2 = 1'b0;
    ps1 = '0; ps2 = '0; pd = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ps1  = prs1_q[k*PREG_W +: PREG_W];
      ps2  = prs2_q[k*PREG_W +: PREG_W];
      pd   = prd_q[k*PREG_W +: PREG_W];
      fire = go & valid_q[k] & (CNT_W'(k) < disp_cnt);
      rob_enq_valid[k]    = fire;
      intisq_enq_valid[k] = fire & ~mem_q[k];
      memisq_enq_valid[k] = fire & mem_q[k];
      bt_alloc_en[k]      = fire & need_wb_q[k] & (pd != '0);
      // Plain binary add: the wrap bit is the carry out of the index field.
      out_robid[k*ROBID_W +: ROBID_W] = rob_tail_robid + ROBID_W'(k);
      bt_rdaddr[2*k*PREG_W +: 2*PREG_W] = {ps2, ps1};
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < NWB; i++) begin
        if (wb_valid[i] && wb_preg[i*PREG_W +: PREG_W] == ps1) hit1 = 1'b1;
        if (wb_valid[i] && wb_preg[i*PREG_W +: PREG_W] == ps2) hit2 = 1'b1;
      end
      // Older lanes firing this cycle allocate only at the edge, so their
      // destinations are not yet visible on bt_busy.
      dep1 = 1'b0;
      dep2 = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (rob_enq_valid[j] && need_wb_q[j] && prd_q[j*PREG_W +: PREG_W] != '0) begin
          if (prd_q[j*PREG_W +: PREG_W] == ps1) dep1 = 1'b1;
          if (prd_q[j*PREG_W +: PREG_W] == ps2) dep2 = 1'b1;
        end
      end
      out_sleep1[k] = src1_q[k] & (ps1 != '0) & ((bt_busy[2*k] & ~hit1) | dep1);
      out_sleep2[k] = src2_q[k] & (ps2 != '0) & ((bt_busy[2*k+1] & ~hit2) | dep2);
    end
  end

  // Next stage contents: flush > load > compaction by disp_cnt.
  always_comb begin
    valid_d   = '0;
    payload_d = payload_q;
    prd_d     = prd_q;
    prs1_d    = prs1_q;
    prs2_d    = prs2_q;
    need_wb_d = need_wb_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    mem_d     = mem_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i + int'(disp_cnt) < WIDTH) begin
        valid_d[i]                     = valid_q[i + int'(disp_cnt)];
        payload_d[i*DATA_W +: DATA_W]  = payload_q[(i + int'(disp_cnt))*DATA_W +: DATA_W];
        prd_d[i*PREG_W +: PREG_W]      = prd_q[(i + int'(disp_cnt))*PREG_W +: PREG_W];
        prs1_d[i*PREG_W +: PREG_W]     = prs1_q[(i + int'(disp_cnt))*PREG_W +: PREG_W];
        prs2_d[i*PREG_W +: PREG_W]     = prs2_q[(i + int'(disp_cnt))*PREG_W +: PREG_W];
        need_wb_d[i]                   = need_wb_q[i + int'(disp_cnt)];
        src1_d[i]                      = src1_q[i + int'(disp_cnt)];
        src2_d[i]                      = src2_q[i + int'(disp_cnt)];
        mem_d[i]                       = mem_q[i + int'(disp_cnt)];
      end
    end
    if (flush_valid) begin
      valid_d = '0;
    end else if (in_valid[0] && in_ready) begin
      valid_d   = in_valid;
      payload_d = in_payload;
      prd_d     = in_prd;
      prs1_d    = in_prs1;
      prs2_d    = in_prs2;
      need_wb_d = in_need_wb;
      src1_d    = in_src1_is_reg;
      src2_d    = in_src2_is_reg;
      mem_d     = in_is_mem;
    end
    stall_d = stall_q;
    if (go && valid_q[0] && disp_cnt == '0 && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
    payload_q <= payload_d;
    prd_q     <= prd_d;
    prs1_q    <= prs1_d;
    prs2_q    <= prs2_d;
    need_wb_q <= need_wb_d;
    src1_q    <= src1_d;
    src2_q    <= src2_d;
    mem_q     <= mem_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dispatch_nw.sv
// Testbench for dispatch_nw: directed test-plan steps followed by randomized
// cycles, all compared against a queue-based reference model of the stage.
module tb_dispatch_nw;
  localparam int WIDTH = 2, DATA_W = 248, PREG_W = 6, ROB_DEPTH = 64;
  localparam int ROBID_W = 7, NWB = 2, CNT_W = 3;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [WIDTH-1:0]          in_valid;
  logic                      in_ready;
  logic [WIDTH*DATA_W-1:0]   in_payload;
  logic [WIDTH*PREG_W-1:0]   in_prd, in_prs1, in_prs2;
  logic [WIDTH-1:0]          in_need_wb, in_src1_is_reg, in_src2_is_reg, in_is_mem;
  logic [CNT_W-1:0]          rob_free, intisq_free, memisq_free;
  logic [ROBID_W-1:0]        rob_tail_robid;
  logic [WIDTH-1:0]          rob_enq_valid, intisq_enq_valid, memisq_enq_valid;
  logic [WIDTH*DATA_W-1:0]   out_payload;
  logic [WIDTH*ROBID_W-1:0]  out_robid;
  logic [WIDTH-1:0]          out_sleep1, out_sleep2;
  logic [2*WIDTH*PREG_W-1:0] bt_rdaddr;
  logic [2*WIDTH-1:0]        bt_busy;
  logic [WIDTH-1:0]          bt_alloc_en;
  logic [WIDTH*PREG_W-1:0]   bt_alloc_addr;
  logic [NWB-1:0]            wb_valid;
  logic [NWB*PREG_W-1:0]     wb_preg;
  logic                      flush_valid;
  logic [31:0]               stall_cycles;

  dispatch_nw #(.WIDTH(WIDTH), .DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_DEPTH(ROB_DEPTH),
                .ROBID_W(ROBID_W), .NWB(NWB), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_prd(in_prd), .in_prs1(in_prs1), .in_prs2(in_prs2),
    .in_need_wb(in_need_wb), .in_src1_is_reg(in_src1_is_reg),
    .in_src2_is_reg(in_src2_is_reg), .in_is_mem(in_is_mem),
    .rob_free(rob_free), .rob_tail_robid(rob_tail_robid),
    .intisq_free(intisq_free), .memisq_free(memisq_free),
    .rob_enq_valid(rob_enq_valid), .intisq_enq_valid(intisq_enq_valid),
    .memisq_enq_valid(memisq_enq_valid), .out_payload(out_payload),
    .out_robid(out_robid), .out_sleep1(out_sleep1), .out_sleep2(out_sleep2),
    .bt_rdaddr(bt_rdaddr), .bt_busy(bt_busy), .bt_alloc_en(bt_alloc_en),
    .bt_alloc_addr(bt_alloc_addr), .wb_valid(wb_valid), .wb_preg(wb_preg),
    .flush_valid(flush_valid), .stall_cycles(stall_cycles)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: pending lanes in program order
  typedef struct {
    logic [DATA_W-1:0] payload;
    logic [PREG_W-1:0] prd, prs1, prs2;
    logic need_wb, s1, s2, mem;
  } lane_t;

  lane_t       model_q[$];
  int unsigned model_stall;
  int          tests_run, tests_failed;
  int          m_d;
  logic        m_go, m_ready;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_sleep(int k, logic is_reg, logic [PREG_W-1:0] ps, logic busy);
    logic wbhit = 1'b0;
    if (!is_reg || ps == 0) return 1'b0;
    for (int i = 0; i < NWB; i++)
      if (wb_valid[i] && wb_preg[i*PREG_W +: PREG_W] == ps) wbhit = 1'b1;
    if (busy && !wbhit) return 1'b1;
    for (int j = 0; j < k; j++)
      if (model_q[j].need_wb && model_q[j].prd == ps) return 1'b1;
    return 1'b0;
  endfunction

  // Compare all outputs against the model, mid-cycle.
  task automatic sample();
    int n, rf, inf, mf, ni, nm;
    logic [WIDTH-1:0] e_rob, e_int, e_mem, e_alloc;
    @(negedge clock);
    n   = model_q.size();
    rf  = (int'(rob_free) > WIDTH) ? WIDTH : int'(rob_free);
    inf = (int'(intisq_free) > WIDTH) ? WIDTH : int'(intisq_free);
    mf  = (int'(memisq_free) > WIDTH) ? WIDTH : int'(memisq_free);
    m_d = 0; ni = 0; nm = 0;
    for (int k = 0; k < n; k++) begin
      if (model_q[k].mem) nm++; else ni++;
      if (k + 1 <= rf && ni <= inf && nm <= mf) m_d = k + 1;
      else break;
    end
    m_go    = !reset && !flush_valid;
    m_ready = m_go && (m_d == n);
    e_rob = '0; e_int = '0; e_mem = '0; e_alloc = '0;
    for (int k = 0; k < n; k++) begin
      chk("bt_rdaddr", bt_rdaddr[2*k*PREG_W +: 2*PREG_W], {model_q[k].prs2, model_q[k].prs1});
      if (m_go && k < m_d) begin
        logic [ROBID_W-1:0] rid;
        rid = rob_tail_robid + ROBID_W'(k);
        e_rob[k]   = 1'b1;
        e_int[k]   = !model_q[k].mem;
        e_mem[k]   = model_q[k].mem;
        e_alloc[k] = model_q[k].need_wb && model_q[k].prd != 0;
        chk("robid", out_robid[k*ROBID_W +: ROBID_W], rid);
        chk("payload", out_payload[k*DATA_W +: DATA_W], model_q[k].payload);
        chk("sleep1", out_sleep1[k], ref_sleep(k, model_q[k].s1, model_q[k].prs1, bt_busy[2*k]));
        chk("sleep2", out_sleep2[k], ref_sleep(k, model_q[k].s2, model_q[k].prs2, bt_busy[2*k+1]));
        if (e_alloc[k]) chk("alloc_addr", bt_alloc_addr[k*PREG_W +: PREG_W], model_q[k].prd);
      end
    end
    chk("rob_enq_valid", rob_enq_valid, e_rob);
    chk("intisq_enq_valid", intisq_enq_valid, e_int);
    chk("memisq_enq_valid", memisq_enq_valid, e_mem);
    chk("bt_alloc_en", bt_alloc_en, e_alloc);
    chk("in_ready", in_ready, m_ready);
    chk("stall_cycles", stall_cycles, model_stall);
  endtask

  // Advance the model and the DUT through one clock edge.
  task automatic advance();
    if (reset) begin
      model_q.delete();
      model_stall = 0;
    end else begin
      if (m_go && model_q.size() > 0 && m_d == 0 && model_stall != 32'hFFFF_FFFF)
        model_stall++;
      if (flush_valid) begin
        model_q.delete();
      end else if (in_valid[0] && m_ready) begin
        model_q.delete();
        for (int k = 0; k < WIDTH; k++) begin
          lane_t l;
          if (in_valid[k]) begin
            l.payload = in_payload[k*DATA_W +: DATA_W];
            l.prd  = in_prd[k*PREG_W +: PREG_W];
            l.prs1 = in_prs1[k*PREG_W +: PREG_W];
            l.prs2 = in_prs2[k*PREG_W +: PREG_W];
            l.need_wb = in_need_wb[k];
            l.s1 = in_src1_is_reg[k];
            l.s2 = in_src2_is_reg[k];
            l.mem = in_is_mem[k];
            model_q.push_back(l);
          end
        end
      end else begin
        for (int k = 0; k < m_d; k++) void'(model_q.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // Driver tasks
  task automatic set_lane(input int k, input logic [PREG_W-1:0] prd, prs1, prs2,
                          input logic nwb, s1, s2, mem);
    logic [255:0] p;
    p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_payload[k*DATA_W +: DATA_W] = p[DATA_W-1:0];
    in_prd[k*PREG_W +: PREG_W]  = prd;
    in_prs1[k*PREG_W +: PREG_W] = prs1;
    in_prs2[k*PREG_W +: PREG_W] = prs2;
    in_need_wb[k] = nwb;
    in_src1_is_reg[k] = s1;
    in_src2_is_reg[k] = s2;
    in_is_mem[k] = mem;
  endtask

  task automatic set_free(input logic [CNT_W-1:0] r, i, m);
    rob_free = r; intisq_free = i; memisq_free = m;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; model_stall = 0;
    reset = 1'b1; flush_valid = 1'b0; in_valid = '0; in_payload = '0;
    in_prd = '0; in_prs1 = '0; in_prs2 = '0; in_need_wb = '0;
    in_src1_is_reg = '0; in_src2_is_reg = '0; in_is_mem = '0;
    set_free(2, 2, 2); rob_tail_robid = 7'd5;
    bt_busy = '0; wb_valid = '0; wb_preg = '0;
    repeat (2) @(posedge clock);
    #1;
    step();                      // outputs quiet while reset is held
    reset = 1'b0;

    // Two int lanes, back-to-back full throughput, ids from tail 5
    set_lane(0, 6'd1, 6'd3, 6'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    set_lane(1, 6'd2, 6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    for (int r = 0; r < 3; r++) begin
      set_lane(0, 6'(10 + r), 6'd3, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      set_lane(1, 6'(20 + r), 6'd5, 6'd6, 1'b0, 1'b1, 1'b1, 1'b0);
      sample();
      chk("tp1_fire", rob_enq_valid, 2'b11);
      chk("tp1_robid0", out_robid[6:0], 7'd5);
      chk("tp1_robid1", out_robid[13:7], 7'd6);
      chk("tp1_ready", in_ready, 1'b1);
      advance();
    end
    in_valid = '0;
    step();

    // ROB has room for one: lane 1 goes a cycle later with the new tail
    set_lane(0, 6'd7, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_lane(1, 6'd8, 6'd7, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    set_free(1, 2, 2);
    sample();
    chk("tp2_fire0", rob_enq_valid, 2'b01);
    chk("tp2_ready0", in_ready, 1'b0);
    advance();
    set_free(2, 2, 2); rob_tail_robid = 7'd6;
    in_valid = '0;
    sample();
    chk("tp2_fire1", rob_enq_valid, 2'b01);
    chk("tp2_robid", out_robid[6:0], 7'd6);
    chk("tp2_ready1", in_ready, 1'b1);
    advance();

    // Memory queue full blocks lane 0, which blocks lane 1
    set_lane(0, 6'd11, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_lane(1, 6'd12, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    in_valid = '0;
    set_free(2, 2, 0);
    sample();
    chk("tp3_blocked", rob_enq_valid, 2'b00);
    advance();
    sample();
    chk("tp3_stall", stall_cycles, 32'd1);
    advance();
    set_free(2, 2, 1);
    sample();
    chk("tp3_both", rob_enq_valid, 2'b11);
    chk("tp3_mem", memisq_enq_valid, 2'b01);
    advance();

    // ROB id wrap
    set_lane(0, 6'd1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 6'd2, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 2'b11; set_free(2, 2, 2);
    step();
    in_valid = '0; rob_tail_robid = 7'h3F;
    sample();
    chk("tp4_robid0", out_robid[6:0], 7'h3F);
    chk("tp4_wrap", out_robid[13:7], 7'h40);
    advance();

    // Intra-group dependence on preg 9
    set_lane(0, 6'd9, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_lane(1, 6'd10, 6'd9, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    in_valid = '0;
    sample();
    chk("tp5_dep", out_sleep1[1], 1'b1);
    advance();
    // Busy but written back this cycle
    set_lane(0, 6'd3, 6'd9, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b01;
    step();
    in_valid = '0; bt_busy = 4'b0001; wb_valid = 2'b01; wb_preg = {6'd0, 6'd9};
    sample();
    chk("tp5_wb_bypass", out_sleep1[0], 1'b0);
    advance();
    // Source preg 0 never sleeps
    set_lane(0, 6'd3, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b01; wb_valid = '0;
    step();
    in_valid = '0;
    sample();
    chk("tp5_p0", out_sleep1[0], 1'b0);
    advance();
    bt_busy = '0;

    // Flush with lane 1 pending
    set_lane(0, 6'd4, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_lane(1, 6'd5, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    in_valid = '0; set_free(1, 2, 2);
    step();
    flush_valid = 1'b1; in_valid = 2'b11;
    sample();
    chk("tp6_flush_quiet", rob_enq_valid, 2'b00);
    chk("tp6_flush_ready", in_ready, 1'b0);
    advance();
    flush_valid = 1'b0; in_valid = '0;
    sample();
    chk("tp6_empty", rob_enq_valid, 2'b00);
    advance();

    // Reset mid-bundle while stalled
    in_valid = 2'b11;
    step();
    in_valid = '0; set_free(0, 2, 2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; set_free(2, 2, 2);
    sample();
    chk("tp6_reset_quiet", rob_enq_valid, 2'b00);
    chk("tp6_reset_stall", stall_cycles, 32'd0);
    advance();

    // Randomized cycles
    for (int c = 0; c < 600; c++) begin
      int nv;
      reset       = ($urandom_range(0, 99) == 0);
      flush_valid = ($urandom_range(0, 24) == 0);
      nv = $urandom_range(0, WIDTH);
      in_valid = WIDTH'((1 << nv) - 1);
      for (int k = 0; k < WIDTH; k++)
        set_lane(k, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                 6'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
      rob_free    = CNT_W'($urandom_range(0, 7));
      intisq_free = CNT_W'($urandom_range(0, 3));
      memisq_free = CNT_W'($urandom_range(0, 3));
      rob_tail_robid = ROBID_W'($urandom);
      bt_busy  = (2*WIDTH)'($urandom);
      wb_valid = NWB'($urandom);
      for (int i = 0; i < NWB; i++) wb_preg[i*PREG_W +: PREG_W] = 6'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
